serial_mag_compare_ctrl: RTL

SERIAL_MAG_COMPARE_CTRL -- requirements
Module: serial_mag_compare_ctrl

---
 rtl/serial_mag_compare_ctrl_if.sv | 24 ++
 rtl/serial_mag_compare_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/serial_mag_compare_ctrl_if.sv
// Request/result bundle for the serial magnitude comparator.
// The requester uses master; the comparator uses slave.
interface serial_mag_compare_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic             eq_o;
    logic             gt_o;
    logic             lt_o;

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, eq_o, gt_o, lt_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, eq_o, gt_o, lt_o
    );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// Serial MSB-first unsigned magnitude comparator: WIDTH compare cycles plus one DONE cycle.
// Define EARLY_EXIT_EN to finish on the first differing bit; start is ignored while busy.
module smc_bit_cell (
    input  logic a_i,
    input  logic b_i,
    output logic eq_o,
    output logic gt_o,
    output logic lt_o
);
    assign eq_o = ~(a_i ^ b_i);
    assign gt_o = a_i & ~b_i;
    assign lt_o = ~a_i & b_i;
endmodule

module serial_mag_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_mag_compare_ctrl_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             gt_pend_q, gt_pend_d;
    logic             lt_pend_q, lt_pend_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic cell_eq, cell_gt, cell_lt;
    logic found;
    logic finish;

    smc_bit_cell u_cell (
        .a_i  (a_q[idx_q]),
        .b_i  (b_q[idx_q]),
        .eq_o (cell_eq),
        .gt_o (cell_gt),
        .lt_o (cell_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gt_pend_q <= 1'b0;
            lt_pend_q <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            gt_pend_q <= gt_pend_d;
            lt_pend_q <= lt_pend_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        gt_pend_d = gt_pend_q;
        lt_pend_d = lt_pend_q;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        found     = 1'b0;
        finish    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    a_d       = bus.a_i;
                    b_d       = bus.b_i;
                    idx_d     = IW'(WIDTH - 1);
                    decided_d = 1'b0;
                    gt_pend_d = 1'b0;
                    lt_pend_d = 1'b0;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                // Only the most significant differing bit decides the result.
                found = ~cell_eq & ~decided_q;
                if (found) begin
                    decided_d = 1'b1;
                    gt_pend_d = cell_gt;
                    lt_pend_d = cell_lt;
                end
`ifdef EARLY_EXIT_EN
                finish = (idx_q == '0) | found;
`else
                finish = (idx_q == '0);
`endif
                // Results land on the DONE entry edge so they are valid with done.
                if (finish) begin
                    state_d = DONE;
                    eq_d    = ~decided_d;
                    gt_d    = gt_pend_d;
                    lt_d    = lt_pend_d;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy_o = (state_q != IDLE);
    assign bus.done_o = (state_q == DONE);
    assign bus.eq_o   = eq_q;
    assign bus.gt_o   = gt_q;
    assign bus.lt_o   = lt_q;
endmodule
